// File: rtl/imem_loader_if.sv
// Boot-link byte stream plus instruction-memory write port of the loader.
// master: loader side (consumes the stream, drives the memory write port).
// slave:  environment side (byte source and instruction memory).
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a byte-serial program image (LEN_HI, LEN_LO, then
// N big-endian 32-bit words) and writes it into instruction memory starting
// at BASE_ADDR, holding the core until the whole image is in place.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When defined, one extra
// byte after the payload must equal the XOR of all payload bytes before the
// core is released; words are still written as they arrive.
//
// The word index and length are 16 bits wide, so ADDR_W must be <= 16.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          core_hold,
    output logic          done,
    output logic          error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR, S_CHK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR
    } state_t;
`endif

    // Largest word count that fits between BASE_ADDR and the top of memory.
    localparam logic [16:0] MAX_LEN = 17'((32'd1 << ADDR_W) - 32'(BASE_ADDR));

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              core_hold_q, core_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic        fire;
    logic [15:0] new_len;

    assign fire    = bus.in_valid && in_ready_q;
    assign new_len = {len_q[15:8], bus.in_data};

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d       = xor_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (fire) begin
                    len_d[15:8] = bus.in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (fire) begin
                    len_d      = new_len;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d      = '0;
`endif
                    // Zero or oversized images are rejected before any write.
                    if (new_len != 16'd0 && {1'b0, new_len} <= MAX_LEN)
                        state_d = S_DATA;
                    else
                        state_d = S_ERR;
                end
            end
            S_DATA: begin
                if (fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ bus.in_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ADDR_W'(BASE_ADDR) + word_idx_q[ADDR_W-1:0];
                        mem_wdata_d = {shift_q, bus.in_data};
                        word_idx_d  = word_idx_q + 16'd1;
                        byte_cnt_d  = 2'd0;
                        if (word_idx_q == len_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_DONE;
`endif
                        end
                    end else begin
                        shift_d    = {shift_q[15:0], bus.in_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (fire) state_d = (bus.in_data == xor_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (start) state_d = S_LEN_HI;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (state_d == S_CHK)
`endif
                     ;
        // done follows the state by one cycle so the final write (first
        // cycle of DONE) lands before the core is released.
        done_d      = (state_q == S_DONE) && !start;
        core_hold_d = !done_d;
        error_d     = (state_d == S_ERR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_hold_q <= core_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign core_hold     = core_hold_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: image tasks push the expected memory
// writes (derived from the image format) into a queue; a negedge monitor
// pops and compares every mem_we cycle and mirrors writes into a memory.
module tb_imem_loader;
    localparam int ADDR_W    = 4;
    localparam int BASE_ADDR = 0;
    localparam int DEPTH     = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic rst, start;
    logic core_hold, done, error;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .core_hold(core_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    wr_t  exp_q[$];
    logic [31:0] shadow [DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        wr_t e;
        if (bus.mem_we === 1'b1) begin
            shadow[bus.mem_addr] <= bus.mem_wdata;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 64'(bus.mem_addr), 64'(e.addr));
                chk("write_data", 64'(bus.mem_wdata), 64'(e.data));
            end
        end
    end

    function automatic bq_t rand_image(input int n);
        bq_t q;
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom_range(255)));
        return q;
    endfunction

    task automatic check_reset_outputs();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_core_hold", 64'(core_hold), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
    endtask

    // Drive n bytes of tx with random gaps; returns after the last byte is
    // presented to a ready loader (it is taken at the following posedge).
    task automatic send(input bq_t tx, input int n, input int gap_pct, input int mid_at);
        int  i = 0;
        int  guard = 0;
        bit  held = 1'b0;
        while (i < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            start = (mid_at >= 0 && i == mid_at);
            if (!held && $urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = tx[i];
                held = !bus.in_ready;
                if (bus.in_ready) i++;
            end
        end
        if (i < n) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got %0d bytes accepted expected %0d", i, n);
        end
    endtask

    task automatic run_image(input bq_t img, input int gap_pct, input int mid_at, input int ck_flip);
        int         n;
        bit         len_ok, expect_done;
        logic [7:0] x;
        logic [31:0] w;
        bq_t        tx;
        n      = int'({img[0], img[1]});
        len_ok = (n >= 1) && (n <= DEPTH - BASE_ADDR);
        x      = 8'h00;
        if (len_ok) begin
            tx = img;
            for (int k = 0; k < n; k++) begin
                w = {img[2+4*k], img[3+4*k], img[4+4*k], img[5+4*k]};
                x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
                exp_q.push_back({ADDR_W'(BASE_ADDR + k), w});
            end
            if (CK) tx.push_back(x ^ 8'(ck_flip));
        end else begin
            tx = img[0:1];
        end
        expect_done = len_ok && (!CK || ck_flip == 0);

        @(negedge clk);
        chk("ready_before_start", 64'(bus.in_ready), 64'd0);
        // start together with a valid first byte: the byte must not be taken yet
        start        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = tx[0];
        send(tx, tx.size(), gap_pct, mid_at);
        @(negedge clk);
        start        = 1'b0;
        bus.in_valid = 1'b0;
        if (expect_done) begin
            chk("done_first_cycle", 64'(done), 64'd0);
            chk("hold_first_cycle", 64'(core_hold), 64'd1);
            @(negedge clk);
            chk("done", 64'(done), 64'd1);
            chk("core_hold_released", 64'(core_hold), 64'd0);
            chk("in_ready_done", 64'(bus.in_ready), 64'd0);
            chk("error_clear", 64'(error), 64'd0);
        end else begin
            chk("error", 64'(error), 64'd1);
            chk("core_hold_err", 64'(core_hold), 64'd1);
            chk("done_clear", 64'(done), 64'd0);
            chk("in_ready_err", 64'(bus.in_ready), 64'd0);
        end
        chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        bq_t img;
        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Reference image from the worked example
        img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h29, 8'hFF, 8'hFF};
        run_image(img, 0, -1, 0);
        chk("plan_word0", 64'(shadow[0]), 64'h20080005);
        chk("plan_word1", 64'(shadow[1]), 64'h2129FFFF);

        // Zero length, then recovery
        run_image('{8'h00, 8'h00}, 0, -1, 0);
        run_image(rand_image(3), 20, -1, 0);

        // Length bounds for a 16-word memory
        run_image('{8'h00, 8'h11}, 0, -1, 0);
        run_image(rand_image(16), 10, -1, 0);

        // Gaps plus an ignored start pulse mid-payload
        run_image(rand_image(3), 50, 7, 0);

        // Reset after the 6th accepted byte of a 2-word image
        img = rand_image(2);
        exp_q.push_back({ADDR_W'(BASE_ADDR), img[2], img[3], img[4], img[5]});
        @(negedge clk);
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = img[0];
        send(img, 6, 0, -1);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_writes_seen", 64'(exp_q.size()), 64'd0);
        chk("reset_hold", 64'(core_hold), 64'd1);

        // Random images, occasionally oversized
        for (int t = 0; t < 5; t++) begin
            if ($urandom_range(4) == 0)
                run_image('{8'h00, 8'(17 + $urandom_range(40))}, 0, -1, 0);
            else
                run_image(rand_image(1 + $urandom_range(15)), $urandom_range(60), -1, 0);
        end

        if (CK) begin
            img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
            run_image(img, 0, -1, 0);
            run_image(img, 0, -1, 1);
            chk("ck_fail_word0", 64'(shadow[0]), 64'h12345678);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
